// File: rtl/roulette_spin_ctrl_if.sv
// Spin-controller handshake bundle: request, seed and tick in; position, step and result out.
// Latency: pure wiring; the timing of every signal is set by roulette_spin_ctrl.
// Backpressure: none; requests arriving while a spin is in progress are dropped, not queued.
// Optional feature macro: SPIN_ABORT_EN adds the spin_abort request line.
interface roulette_spin_ctrl_if;
  logic        spin_req;
  logic [15:0] seed;
  logic        tick;
`ifdef SPIN_ABORT_EN
  logic        spin_abort;
`endif
  logic        busy;
  logic [5:0]  pocket_pos;
  logic        step_pulse;
  logic        result_valid;
  logic [5:0]  result;

  // Game logic / timer side: issues requests and ticks, observes the wheel.
  modport master (
    output spin_req, seed, tick,
`ifdef SPIN_ABORT_EN
    output spin_abort,
`endif
    input  busy, pocket_pos, step_pulse, result_valid, result
  );

  // Controller side.
  modport slave (
    input  spin_req, seed, tick,
`ifdef SPIN_ABORT_EN
    input  spin_abort,
`endif
    output busy, pocket_pos, step_pulse, result_valid, result
  );
endinterface

// File: rtl/roulette_spin_ctrl.sv
// Roulette wheel spin controller: full-speed stepping, staged slow-down, then the winning pocket is reported.
// Latency: outputs registered; result_valid rises one edge after the final advance tick (or after the abort).
// Backpressure: none; spin_req is honoured only in IDLE, and ticks outside FAST/DECEL are dropped.
// Optional feature macro: SPIN_ABORT_EN adds spin_abort (jump to DONE without stepping).
module roulette_spin_ctrl #(
  parameter int NUM_POCKETS = 37,
  parameter int MAX_DIVIDER = 16,
  parameter int DECEL_STEPS = 4,
  parameter int DIV_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  roulette_spin_ctrl_if.slave  spin_if
);

  localparam int FAST_W = $clog2(NUM_POCKETS + 64);
  localparam int LVL_W  = $clog2(DECEL_STEPS + 1);

  localparam logic [5:0]        NUM_POS6  = 6'(NUM_POCKETS);
  localparam logic [5:0]        LAST_POS  = 6'(NUM_POCKETS - 1);
  localparam logic [DIV_W-1:0]  MAX_DIV   = DIV_W'(MAX_DIVIDER);
  localparam logic [LVL_W-1:0]  LVL_RLD   = LVL_W'(DECEL_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_FAST, S_DECEL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [5:0]          pocket_pos_q, pocket_pos_d;
  logic [FAST_W-1:0]   fast_left_q, fast_left_d;
  logic [LVL_W-1:0]    level_left_q, level_left_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                busy_q, busy_d;
  logic                step_pulse_q, step_pulse_d;
  logic                result_valid_q, result_valid_d;
  logic [5:0]          result_q, result_d;

  logic                running;
  logic                abort_req;
  logic                advance;
  logic                fast_last;
  logic                level_last;
  logic                at_max_div;
  logic [5:0]          start_raw;
  logic [5:0]          start_pos;
  logic [FAST_W-1:0]   fast_count;
  logic [5:0]          next_pos;
  logic                unused_seed_hi;

  // Only seed[11:0] carries start position and fast length; the top nibble is deliberately dropped.
  assign unused_seed_hi = ^spin_if.seed[15:12];

  assign running = (state_q == S_FAST) || (state_q == S_DECEL);

`ifdef SPIN_ABORT_EN
  assign abort_req = running && spin_if.spin_abort;
`else
  assign abort_req = 1'b0;
`endif

  // An abort wins over a coincident advance so the reported pocket is the one on display.
  assign advance    = running && spin_if.tick && !abort_req &&
                      ((tick_cnt_q + DIV_W'(1)) == div_q);
  assign fast_last  = (fast_left_q == FAST_W'(1));
  assign level_last = (level_left_q == LVL_W'(1));
  assign at_max_div = (div_q >= MAX_DIV);

  // seed[11:6] spans 0..63, so a single conditional subtract folds it onto 0..36.
  assign start_raw  = spin_if.seed[11:6];
  assign start_pos  = (start_raw < NUM_POS6) ? start_raw : (start_raw - NUM_POS6);
  assign fast_count = FAST_W'(NUM_POCKETS) + FAST_W'(spin_if.seed[5:0]);
  assign next_pos   = (pocket_pos_q == LAST_POS) ? 6'd0 : (pocket_pos_q + 6'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (spin_if.spin_req) state_d = S_FAST;
      S_FAST: begin
        if (abort_req)                   state_d = S_DONE;
        else if (advance && fast_last)   state_d = S_DECEL;
      end
      S_DECEL: begin
        if (abort_req)                                   state_d = S_DONE;
        else if (advance && level_last && at_max_div)    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    pocket_pos_d   = pocket_pos_q;
    fast_left_d    = fast_left_q;
    level_left_d   = level_left_q;
    div_d          = div_q;
    tick_cnt_d     = tick_cnt_q;
    busy_d         = busy_q;
    step_pulse_d   = 1'b0;
    result_valid_d = 1'b0;
    result_d       = result_q;

    if (state_q == S_IDLE) begin
      if (spin_if.spin_req) begin
        pocket_pos_d = start_pos;
        fast_left_d  = fast_count;
        level_left_d = '0;
        div_d        = DIV_W'(1);
        tick_cnt_d   = '0;
        busy_d       = 1'b1;
      end
    end else if (state_q == S_DONE) begin
      busy_d = 1'b0;
    end else if (spin_if.tick && !abort_req) begin
      if (advance) begin
        pocket_pos_d = next_pos;
        step_pulse_d = 1'b1;
        tick_cnt_d   = '0;
        if (state_q == S_FAST) begin
          fast_left_d = fast_left_q - FAST_W'(1);
          if (fast_last) begin
            div_d        = DIV_W'(2);
            level_left_d = LVL_RLD;
          end
        end else begin
          level_left_d = level_left_q - LVL_W'(1);
          if (level_last && !at_max_div) begin
            div_d        = div_q + DIV_W'(1);
            level_left_d = LVL_RLD;
          end
        end
      end else begin
        tick_cnt_d = tick_cnt_q + DIV_W'(1);
      end
    end

    // Capture on entry to DONE, using the post-advance position of that same edge.
    if (state_d == S_DONE) begin
      result_d       = pocket_pos_d;
      result_valid_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pocket_pos_q   <= '0;
      fast_left_q    <= '0;
      level_left_q   <= '0;
      div_q          <= '0;
      tick_cnt_q     <= '0;
      busy_q         <= 1'b0;
      step_pulse_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      pocket_pos_q   <= pocket_pos_d;
      fast_left_q    <= fast_left_d;
      level_left_q   <= level_left_d;
      div_q          <= div_d;
      tick_cnt_q     <= tick_cnt_d;
      busy_q         <= busy_d;
      step_pulse_q   <= step_pulse_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
    end
  end

  assign spin_if.busy         = busy_q;
  assign spin_if.pocket_pos   = pocket_pos_q;
  assign spin_if.step_pulse   = step_pulse_q;
  assign spin_if.result_valid = result_valid_q;
  assign spin_if.result       = result_q;

endmodule

// File: tb/tb_roulette_spin_ctrl.sv
// Bench for roulette_spin_ctrl: directed spins, scoreboard queue of expected results, decoupled monitor.
// Latency: ticks every 10 clocks; the monitor samples on the falling edge.
// Backpressure: none; ignored requests are checked through busy and the held result.
module tb_roulette_spin_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  roulette_spin_ctrl_if sif ();

  roulette_spin_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .spin_if (sif)
  );

  typedef struct {
    int result;
    int steps;
    int ticks;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int step_cnt = 0;
  int tick_cnt = 0;
  int done_cnt = 0;
  int wrap_cnt = 0;
  int prev_pos = 0;
  bit chk_idle = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: counts steps and consumed ticks, pops the scoreboard on every result_valid.
  always @(negedge clk) begin
    if (rst) begin
      if (chk_idle) begin
        check("busy_low_after_done", int'(sif.busy), 0);
        check("result_valid_single_pulse", int'(sif.result_valid), 0);
        chk_idle = 1'b0;
      end
      if (sif.step_pulse) begin
        step_cnt++;
        check("step_advances_by_one", int'(sif.pocket_pos), (prev_pos + 1) % 37);
        if (prev_pos == 36 && sif.pocket_pos == 6'd0) wrap_cnt++;
      end
      if (sif.tick && sif.busy && !sif.result_valid) tick_cnt++;
      if (sif.result_valid) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0d expected=none", sif.result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_pocket", int'(sif.result), e.result);
          check("step_count", step_cnt, e.steps);
          check("tick_count", tick_cnt, e.ticks);
        end
        step_cnt = 0;
        tick_cnt = 0;
        chk_idle = 1'b1;
      end
    end
    prev_pos = int'(sif.pocket_pos);
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One tick pulse followed by 9 idle clocks; optionally fires spin_req in the DONE cycle.
  task automatic issue_tick(input bit req_in_done);
    sif.tick = 1'b1;
    step_clk();
    sif.tick = 1'b0;
    if (req_in_done && sif.result_valid) begin
      sif.spin_req = 1'b1;
      sif.seed     = 16'h0A00;
      step_clk();
      sif.spin_req = 1'b0;
      repeat (8) step_clk();
    end else begin
      repeat (9) step_clk();
    end
  endtask

  task automatic start_spin(input logic [15:0] sd, input bit with_tick);
    sif.seed     = sd;
    sif.spin_req = 1'b1;
    sif.tick     = with_tick;
    step_clk();
    sif.spin_req = 1'b0;
    sif.tick     = 1'b0;
    repeat (9) step_clk();
  endtask

  // Ticks until the monitor sees a result or the budget runs out; stray requests at chosen ticks.
  task automatic run_spin(input int limit, input bit req_in_done, input int req_a, input int req_b);
    int start;
    int n;
    start = done_cnt;
    n     = 0;
    while (done_cnt == start && n < limit) begin
      if (n == req_a || n == req_b) begin
        sif.spin_req = 1'b1;
        sif.seed     = 16'h0A00;
        step_clk();
        sif.spin_req = 1'b0;
      end
      issue_tick(req_in_done);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL spin_timeout actual=%0d ticks expected=result_valid", n);
    end
    repeat (3) step_clk();
  endtask

  task automatic push_exp(input int r, input int s, input int t);
    exp_t e;
    e.result = r;
    e.steps  = s;
    e.ticks  = t;
    exp_q.push_back(e);
  endtask

  initial begin
    int wraps_before;
    rst          = 1'b0;
    sif.spin_req = 1'b0;
    sif.seed     = 16'h0000;
    sif.tick     = 1'b0;
`ifdef SPIN_ABORT_EN
    sif.spin_abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(sif.busy), 0);
    check("reset_pocket_pos", int'(sif.pocket_pos), 0);
    check("reset_result", int'(sif.result), 0);
    check("reset_result_valid", int'(sif.result_valid), 0);
    check("reset_step_pulse", int'(sif.step_pulse), 0);
    rst = 1'b1;
    repeat (2) step_clk();

    // Basic spin, seed 0: start 0, 97 steps, 577 ticks, pocket 23.
    push_exp(23, 97, 577);
    start_spin(16'h0000, 1'b0);
    check("busy_after_accept", int'(sif.busy), 1);
    run_spin(800, 1'b0, -1, -1);
    check("result_held", int'(sif.result), 23);

    // Reset mid-spin at tick 50: asynchronous, between edges; no result may follow.
    start_spin(16'h0000, 1'b0);
    repeat (50) issue_tick(1'b0);
    check("midspin_busy", int'(sif.busy), 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", int'(sif.busy), 0);
    check("async_rst_pocket_pos", int'(sif.pocket_pos), 0);
    check("async_rst_result", int'(sif.result), 0);
    check("async_rst_result_valid", int'(sif.result_valid), 0);
    step_cnt = 0;
    tick_cnt = 0;
    chk_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) step_clk();
    check("no_result_after_abort_rst", done_cnt, 1);

    // Longest fast run: seed 003F -> 160 steps, 640 ticks, pocket 12.
    push_exp(12, 160, 640);
    start_spin(16'h003F, 1'b0);
    run_spin(800, 1'b0, -1, -1);

    // Start-position fold: seed[11:6]=40 -> start 3; 97 steps end on 26 with two 36->0 wraps.
    wraps_before = wrap_cnt;
    push_exp(26, 97, 577);
    start_spin(16'h0A00, 1'b0);
    check("start_pos_folded", int'(sif.pocket_pos), 3);
    run_spin(800, 1'b0, -1, -1);
    check("wrap_count", wrap_cnt - wraps_before, 2);

    // Ignored requests at ticks 10, 300 and in DONE; coincident tick at accept is not counted.
    push_exp(23, 97, 577);
    start_spin(16'h0000, 1'b1);
    check("coincident_start_pos", int'(sif.pocket_pos), 0);
    run_spin(800, 1'b1, 10, 300);
    repeat (20) step_clk();
    check("no_respin_busy", int'(sif.busy), 0);
    check("no_respin_pocket", int'(sif.pocket_pos), 23);
    check("no_respin_result", int'(sif.result), 23);
    check("scoreboard_drained", exp_q.size(), 0);

`ifdef SPIN_ABORT_EN
    // Abort with the 21st tick: result is the pocket after 20 advances, no 21st step.
    push_exp(20, 20, 21);
    start_spin(16'h0000, 1'b0);
    repeat (20) issue_tick(1'b0);
    sif.spin_abort = 1'b1;
    sif.tick       = 1'b1;
    step_clk();
    sif.spin_abort = 1'b0;
    sif.tick       = 1'b0;
    repeat (9) step_clk();
    check("abort_busy_low", int'(sif.busy), 0);
    check("abort_result", int'(sif.result), 20);
`endif

    check("all_results_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
